// File: rtl/wb_stage.sv
// Dual-lane writeback stage: register-file writes, forwarding and exception hand-off to the CSR unit.
// Optional commit counter output is enabled by defining WB_PERF_CNT_EN.
module wb_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         line1_pre_to_now_valid_i,
  input  logic         line2_pre_to_now_valid_i,
  output logic         now_allowin_o,
  input  logic [141:0] pre_to_ibus,
  output logic         rf1_we_o,
  output logic [4:0]   rf1_waddr_o,
  output logic [31:0]  rf1_wdata_o,
  output logic         rf2_we_o,
  output logic [4:0]   rf2_waddr_o,
  output logic [31:0]  rf2_wdata_o,
  output logic [75:0]  forward_obus,
  output logic         excep_req_o,
  output logic [31:0]  excep_pc_o,
  input  logic         excep_ack_i,
  output logic         excep_flush_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]  commit_cnt_o
`endif
);

  // Handshake: the stage accepts a new lane pair on every clock edge where
  // now_allowin_o=1; a lane is present when its valid input is 1 at that edge.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXCEP_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        line1_valid, line2_valid;
  logic [70:0] line1_data, line2_data;
  logic        in_idle;
  logic        l1_exc, l2_exc, take_excep;
  logic        rf1_we_raw;

  assign in_idle    = (state_q == IDLE);
  assign l1_exc     = line1_valid & line1_data[70];
  assign l2_exc     = line2_valid & line2_data[70] & ~l1_exc;
  assign take_excep = l1_exc | l2_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (take_excep) state_d = EXCEP_WAIT;
      EXCEP_WAIT: if (excep_ack_i) state_d = FLUSH;
      FLUSH:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Stage registers; payload keeps its old value when the incoming lane is invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line1_valid <= 1'b0;
      line2_valid <= 1'b0;
      line1_data  <= '0;
      line2_data  <= '0;
    end else if (now_allowin_o) begin
      line1_valid <= line1_pre_to_now_valid_i;
      line2_valid <= line2_pre_to_now_valid_i;
      if (line1_pre_to_now_valid_i) line1_data <= pre_to_ibus[70:0];
      if (line2_pre_to_now_valid_i) line2_data <= pre_to_ibus[141:71];
    end else if (state_q == FLUSH) begin
      line1_valid <= 1'b0;
      line2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excep_pc_o <= '0;
    end else if (in_idle && take_excep) begin
      excep_pc_o <= l1_exc ? line1_data[31:0] : line2_data[31:0];
    end
  end

  assign now_allowin_o = in_idle;
  assign excep_req_o   = (state_q == EXCEP_WAIT);
  assign excep_flush_o = (state_q == FLUSH);

  // Lane2 is squashed by an older lane1 exception; on a same-register
  // collision the younger lane2 write is the one that survives.
  assign rf2_we_o = in_idle & line2_valid & line2_data[32] & ~line2_data[70]
                  & (line2_data[37:33] != 5'd0) & ~l1_exc;
  assign rf1_we_raw = in_idle & line1_valid & line1_data[32] & ~line1_data[70]
                    & (line1_data[37:33] != 5'd0);
  assign rf1_we_o = rf1_we_raw & ~(rf2_we_o & (line2_data[37:33] == line1_data[37:33]));

  assign rf1_waddr_o = line1_data[37:33];
  assign rf1_wdata_o = line1_data[69:38];
  assign rf2_waddr_o = line2_data[37:33];
  assign rf2_wdata_o = line2_data[69:38];

  assign forward_obus = {rf2_we_o, rf2_waddr_o, rf2_wdata_o,
                         rf1_we_o, rf1_waddr_o, rf1_wdata_o};

`ifdef WB_PERF_CNT_EN
  logic commit1, commit2;
  assign commit1 = in_idle & line1_valid & ~line1_data[70];
  assign commit2 = in_idle & line2_valid & ~line2_data[70] & ~l1_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_o <= '0;
    end else begin
      commit_cnt_o <= commit_cnt_o + 32'(commit1) + 32'(commit2);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then randomized traffic against a lane-level reference model.
// Commit counter checks are compiled in only when WB_PERF_CNT_EN is defined.
module tb_wb_stage;

  typedef struct packed {
    logic        ex;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] pc;
  } lane_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         v1_in = 1'b0, v2_in = 1'b0;
  lane_t        l1_in, l2_in;
  logic [141:0] pre_to_ibus;
  logic         excep_ack = 1'b0;
  logic         now_allowin, rf1_we, rf2_we, excep_req, excep_flush;
  logic [4:0]   rf1_waddr, rf2_waddr;
  logic [31:0]  rf1_wdata, rf2_wdata, excep_pc;
  logic [75:0]  forward_obus;
`ifdef WB_PERF_CNT_EN
  logic [31:0]  commit_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: what sits in the stage, what phase the exception
  // hand-off is in, the latched exception PC and the running commit count.
  logic        m_v1, m_v2;
  lane_t       m_l1, m_l2;
  int          m_phase;   // 0 accepting, 1 waiting for ack, 2 flushing
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  assign pre_to_ibus = {l2_in, l1_in};

  always #5 clk = ~clk;

  wb_stage dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .line1_pre_to_now_valid_i (v1_in),
    .line2_pre_to_now_valid_i (v2_in),
    .now_allowin_o            (now_allowin),
    .pre_to_ibus              (pre_to_ibus),
    .rf1_we_o                 (rf1_we),
    .rf1_waddr_o              (rf1_waddr),
    .rf1_wdata_o              (rf1_wdata),
    .rf2_we_o                 (rf2_we),
    .rf2_waddr_o              (rf2_waddr),
    .rf2_wdata_o              (rf2_wdata),
    .forward_obus             (forward_obus),
    .excep_req_o              (excep_req),
    .excep_pc_o               (excep_pc),
    .excep_ack_i              (excep_ack),
    .excep_flush_o            (excep_flush)
`ifdef WB_PERF_CNT_EN
    ,
    .commit_cnt_o             (commit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic lane_t mk(input logic ex, input logic [31:0] data,
                               input logic [4:0] addr, input logic we, input logic [31:0] pc);
    lane_t l;
    l.ex = ex; l.data = data; l.addr = addr; l.we = we; l.pc = pc;
    return l;
  endfunction

  task automatic model_reset();
    m_v1 = 1'b0; m_v2 = 1'b0; m_l1 = '0; m_l2 = '0;
    m_phase = 0; m_pc = '0; m_cnt = '0;
  endtask

  // Which lanes should write this cycle, straight from the architectural rules.
  task automatic expect_writes(output logic e1, output logic e2);
    logic older_exc;
    older_exc = m_v1 && m_l1.ex;
    e2 = (m_phase == 0) && m_v2 && m_l2.we && !m_l2.ex && (m_l2.addr != 0) && !older_exc;
    e1 = (m_phase == 0) && m_v1 && m_l1.we && !m_l1.ex && (m_l1.addr != 0);
    if (e2 && (m_l2.addr == m_l1.addr)) e1 = 1'b0;
  endtask

  task automatic model_clock();
    logic exc1, exc2;
    case (m_phase)
      0: begin
        exc1 = m_v1 && m_l1.ex;
        exc2 = m_v2 && m_l2.ex && !exc1;
        m_cnt = m_cnt + ((m_v1 && !m_l1.ex) ? 1 : 0) + ((m_v2 && !m_l2.ex && !exc1) ? 1 : 0);
        if (exc1 || exc2) begin
          m_pc = exc1 ? m_l1.pc : m_l2.pc;
          m_phase = 1;
        end
        m_v1 = v1_in; m_v2 = v2_in;
        if (v1_in) m_l1 = l1_in;
        if (v2_in) m_l2 = l2_in;
      end
      1: if (excep_ack) m_phase = 2;
      default: begin
        m_v1 = 1'b0; m_v2 = 1'b0; m_phase = 0;
      end
    endcase
  endtask

  task automatic check_all();
    logic e1, e2;
    expect_writes(e1, e2);
    chk("allowin", now_allowin, m_phase == 0);
    chk("excep_req", excep_req, m_phase == 1);
    chk("excep_flush", excep_flush, m_phase == 2);
    chk("excep_pc", excep_pc, m_pc);
    chk("rf1_we", rf1_we, e1);
    chk("rf2_we", rf2_we, e2);
    chk("fwd_we", {forward_obus[75], forward_obus[37]}, {e2, e1});
    if (e1) begin
      chk("rf1_waddr", rf1_waddr, m_l1.addr);
      chk("rf1_wdata", rf1_wdata, m_l1.data);
      chk("fwd1", forward_obus[36:0], {m_l1.addr, m_l1.data});
    end
    if (e2) begin
      chk("rf2_waddr", rf2_waddr, m_l2.addr);
      chk("rf2_wdata", rf2_wdata, m_l2.data);
      chk("fwd2", forward_obus[74:38], {m_l2.addr, m_l2.data});
    end
`ifdef WB_PERF_CNT_EN
    chk("commit_cnt", commit_cnt, m_cnt);
`endif
  endtask

  // One cycle: drive inputs, clock, advance model, check on the falling edge.
  task automatic step(input logic v1, input lane_t l1, input logic v2, input lane_t l2, input logic ack);
    v1_in = v1; l1_in = l1; v2_in = v2; l2_in = l2; excep_ack = ack;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input logic ack);
    step(1'b0, '0, 1'b0, '0, ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_allowin"}, now_allowin, 1'b1);
    chk({tag, "_zero"}, {rf1_we, rf1_waddr, rf1_wdata, rf2_we, rf2_waddr, rf2_wdata}, '0);
    chk({tag, "_fwd"}, forward_obus, '0);
    chk({tag, "_exc"}, {excep_req, excep_flush, excep_pc}, '0);
`ifdef WB_PERF_CNT_EN
    chk({tag, "_cnt"}, commit_cnt, 32'd0);
`endif
  endtask

  initial begin
    lane_t a, b;
    int wait_n;
    l1_in = '0; l2_in = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Two independent writes in the same cycle
    step(1'b1, mk(0, 32'h11, 5'd3, 1, 32'h1C000000), 1'b1, mk(0, 32'h22, 5'd4, 1, 32'h1C000004), 1'b0);
    chk("dual_rf1", {rf1_we, rf1_waddr, rf1_wdata}, {1'b1, 5'd3, 32'h11});
    chk("dual_rf2", {rf2_we, rf2_waddr, rf2_wdata}, {1'b1, 5'd4, 32'h22});

    // Same destination: the younger lane wins
    step(1'b1, mk(0, 32'hA, 5'd5, 1, 32'h1C000008), 1'b1, mk(0, 32'hB, 5'd5, 1, 32'h1C00000C), 1'b0);
    chk("wwc_rf1", rf1_we, 1'b0);
    chk("wwc_rf2", {rf2_we, rf2_waddr, rf2_wdata}, {1'b1, 5'd5, 32'hB});

    // r0 is never written
    step(1'b1, mk(0, 32'h99, 5'd0, 1, 32'h1C000010), 1'b1, mk(0, 32'h98, 5'd0, 1, 32'h1C000014), 1'b0);
    chk("r0_we", {rf1_we, rf2_we}, 2'b00);

    // Lane1 exception, ack after three waiting cycles
    step(1'b1, mk(1, 32'h77, 5'd6, 1, 32'h1C000100), 1'b0, '0, 1'b0);
    chk("l1exc_nowrite", {rf1_we, rf2_we}, 2'b00);
    idle_step(1'b1);  // ack while still accepting is ignored
    chk("l1exc_req", {excep_req, now_allowin}, 2'b10);
    chk("l1exc_pc", excep_pc, 32'h1C000100);
    idle_step(1'b0);
    idle_step(1'b0);
    idle_step(1'b1);
    chk("l1exc_flush", excep_flush, 1'b1);
    idle_step(1'b0);
    chk("l1exc_back", {excep_flush, now_allowin}, 2'b01);

    // Lane2 exception while lane1 still writes
    step(1'b1, mk(0, 32'h5, 5'd7, 1, 32'h1C000200), 1'b1, mk(1, 32'h6, 5'd8, 1, 32'h1C000204), 1'b0);
    chk("l2exc_rf1", {rf1_we, rf1_waddr, rf1_wdata}, {1'b1, 5'd7, 32'h5});
    chk("l2exc_rf2", rf2_we, 1'b0);
    idle_step(1'b0);
    chk("l2exc_pc", excep_pc, 32'h1C000204);
    idle_step(1'b1);
    idle_step(1'b0);

    // Exception bit on an invalid lane is not an exception
    step(1'b0, mk(1, 32'h1, 5'd1, 1, 32'h1C000300), 1'b1, mk(0, 32'h2, 5'd2, 1, 32'h1C000304), 1'b0);
    idle_step(1'b0);
    chk("inv_exc_noreq", excep_req, 1'b0);

    // Reset in the middle of an exception wait
    step(1'b1, mk(1, 32'h0, 5'd9, 1, 32'h1C000400), 1'b0, '0, 1'b0);
    idle_step(1'b0);
    chk("midrst_pre", excep_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_step(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = mk($urandom_range(0, 7) == 0, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom);
      b = mk($urandom_range(0, 7) == 0, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom);
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, b, $urandom_range(0, 2) == 0);
    end

    // Drain any pending exception so the final state is accepting
    wait_n = 0;
    while (m_phase != 0 && wait_n < 10) begin
      idle_step(1'b1);
      wait_n++;
    end
    chk("drain", now_allowin, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
